// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-precision add/subtract built around one shared
// 32-bit ripple adder. One word is processed per clock, LSW first, with the
// inter-word carry held in a register. Also defines the full_adder_32bit
// datapath it time-shares.

// 32-bit ripple-carry adder used as the only arithmetic element of the sequencer.
module full_adder_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [32:0] carry_w;

  assign carry_w[0] = cin_i;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign sum_o[gi]       = a_i[gi] ^ b_i[gi] ^ carry_w[gi];
    assign carry_w[gi + 1] = (a_i[gi] & b_i[gi]) | (carry_w[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = carry_w[32];

endmodule

module wide_add_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [32*NWORDS-1:0] a,
  input  logic [32*NWORDS-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [32*NWORDS-1:0] result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W    = 32 * NWORDS;
  localparam int IDXW = $clog2(NWORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;      // holds ~b for subtraction
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  // Bit offset of the current word inside the wide operands.
  logic [IDXW+4:0] word_base;
  logic [31:0]     a_word, b_word, sum_w;
  logic            cout_w;

  assign word_base = {idx_q, 5'b00000};
  assign a_word    = a_q[word_base +: 32];
  assign b_word    = b_q[word_base +: 32];

  full_adder_32bit u_adder (
    .a_i    (a_word),
    .b_i    (b_word),
    .cin_i  (carry_q),
    .sum_o  (sum_w),
    .cout_o (cout_w)
  );

  // State and datapath registers; async reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath update: accept in IDLE, one word per cycle in RUN.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
          b_d      = sub ? ~b : b;
          carry_d  = sub;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      RUN: begin
        result_d[word_base +: 32] = sum_w;
        carry_d = cout_w;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = cout_w;
          // Operand signs agree but the result sign differs.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_w[31] != a_q[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (NWORDS = 4, 128-bit operands).
module tb_wide_add_sequencer;

  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  wide_add_sequencer #(.NWORDS(NW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain W-bit arithmetic.
  function automatic void ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input logic sv, output logic [W-1:0] r,
                                    output logic co, output logic ov);
    logic [W:0] full;
    if (!sv) begin
      full = {1'b0, av} + {1'b0, bv};
      co   = full[W];
    end else begin
      full = {1'b0, av} - {1'b0, bv};
      co   = (av >= bv);
    end
    r = full[W-1:0];
    if (!sv) ov = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
    else     ov = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Counts negedges from the current one (1) until done is seen; cyc=0 on timeout.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Drives one request; returns at the negedge where done is high.
  task automatic issue_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          output int cyc, output int busy_cnt);
    @(negedge clk);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, busy_cnt);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b cout=%b ovf=%b result=%h, required all 0",
               busy, done, cout, ovf, result);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_stable cycle %0d: busy=%b done=%b result=%h, required 0", i, busy, done, result);
      end
    end
    $display("test_reset: idle held 10 cycles");
  endtask

  task automatic test_carry();
    logic [W-1:0] av, exp_r;
    int cyc, bc;
    av    = {32'h0, {96{1'b1}}};
    exp_r = {32'h1, 96'h0};
    issue_op(av, 128'd1, 1'b0, cyc, bc);
    n_checks++;
    if (result !== exp_r || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_chain: result=%h cout=%b ovf=%b, required %h 0 0", result, cout, ovf, exp_r);
    end
    n_checks++;
    if (cyc !== NW + 1 || bc !== NW) begin
      n_fail++;
      $display("FAIL carry_timing: done_cycle=%0d busy_cycles=%0d, required %0d %0d", cyc, bc, NW + 1, NW);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp_r) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b result=%h, required 0 0 %h", done, busy, result, exp_r);
    end
    $display("test_carry: result=%h done_cycle=%0d", result, cyc);
  endtask

  task automatic test_wrap();
    logic [W-1:0] ones, maxpos, minneg;
    int cyc, bc;
    ones   = {W{1'b1}};
    maxpos = {1'b0, {(W-1){1'b1}}};
    minneg = {1'b1, {(W-1){1'b0}}};
    issue_op(ones, 128'd1, 1'b0, cyc, bc);
    n_checks++;
    if (result !== '0 || cout !== 1'b1 || ovf !== 1'b0 || cyc !== NW + 1) begin
      n_fail++;
      $display("FAIL full_wrap: result=%h cout=%b ovf=%b cyc=%0d, required 0 1 0 %0d", result, cout, ovf, cyc, NW + 1);
    end
    $display("test_wrap: ones+1 result=%h cout=%b ovf=%b", result, cout, ovf);
    issue_op(maxpos, 128'd1, 1'b0, cyc, bc);
    n_checks++;
    if (result !== minneg || cout !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL pos_overflow: result=%h cout=%b ovf=%b, required %h 0 1", result, cout, ovf, minneg);
    end
    $display("test_wrap: maxpos+1 result=%h cout=%b ovf=%b", result, cout, ovf);
  endtask

  task automatic test_sub();
    logic [W-1:0] exp_r, maxpos, minneg;
    int cyc, bc;
    maxpos = {1'b0, {(W-1){1'b1}}};
    minneg = {1'b1, {(W-1){1'b0}}};
    exp_r  = {{(W-1){1'b1}}, 1'b0};
    issue_op(128'd5, 128'd7, 1'b1, cyc, bc);
    n_checks++;
    if (result !== exp_r || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_5_7: result=%h cout=%b ovf=%b, required %h 0 0", result, cout, ovf, exp_r);
    end
    $display("test_sub: 5-7 result=%h cout=%b", result, cout);
    issue_op(128'd7, 128'd5, 1'b1, cyc, bc);
    n_checks++;
    if (result !== 128'd2 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_7_5: result=%h cout=%b ovf=%b, required 2 1 0", result, cout, ovf);
    end
    $display("test_sub: 7-5 result=%h cout=%b", result, cout);
    issue_op(minneg, 128'd1, 1'b1, cyc, bc);
    n_checks++;
    if (result !== maxpos || cout !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_neg_overflow: result=%h cout=%b ovf=%b, required %h 1 1", result, cout, ovf, maxpos);
    end
    $display("test_sub: minneg-1 result=%h ovf=%b", result, ovf);
  endtask

  task automatic test_handshake();
    logic [W-1:0] a1, b1, exp_r;
    logic exp_c, exp_o;
    int cyc, bc;
    a1 = rand_wide();
    b1 = rand_wide();
    ref_model(a1, b1, 1'b0, exp_r, exp_c, exp_o);
    @(negedge clk);
    a = a1; b = b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = rand_wide(); b = rand_wide(); sub = 1'b1;
    @(negedge clk);
    start = 1'b1; a = rand_wide();
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    n_checks++;
    if (result !== exp_r || cout !== exp_c || ovf !== exp_o || cyc == 0) begin
      n_fail++;
      $display("FAIL ignore_start: result=%h cout=%b ovf=%b, required %h %b %b", result, cout, ovf, exp_r, exp_c, exp_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== exp_r) begin
        n_fail++;
        $display("FAIL no_queue cycle %0d: busy=%b done=%b result=%h", i, busy, done, result);
      end
    end
    $display("test_handshake: mid-run start/operand change ignored, result=%h", result);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, r1, r2;
    logic c1, o1, c2, o2;
    int cyc, bc;
    a1 = rand_wide(); b1 = rand_wide();
    a2 = rand_wide(); b2 = rand_wide();
    ref_model(a1, b1, 1'b1, r1, c1, o1);
    ref_model(a2, b2, 1'b0, r2, c2, o2);
    @(negedge clk);
    a = a1; b = b1; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    wait_done(cyc, bc);
    n_checks++;
    if (result !== r1 || cout !== c1 || ovf !== o1 || cyc !== NW + 1) begin
      n_fail++;
      $display("FAIL b2b_first: result=%h cout=%b ovf=%b cyc=%0d, required %h %b %b %0d",
               result, cout, ovf, cyc, r1, c1, o1, NW + 1);
    end
    a = a2; b = b2; sub = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b, required 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || result !== '0) begin
      n_fail++;
      $display("FAIL b2b_reaccept: busy=%b result=%h, required 1 0", busy, result);
    end
    wait_done(cyc, bc);
    n_checks++;
    if (result !== r2 || cout !== c2 || ovf !== o2 || cyc !== NW + 1) begin
      n_fail++;
      $display("FAIL b2b_second: result=%h cout=%b ovf=%b cyc=%0d, required %h %b %b %0d",
               result, cout, ovf, cyc, r2, c2, o2, NW + 1);
    end
    $display("test_back_to_back: second result=%h", result);
  endtask

  task automatic test_reset_mid();
    int cyc, bc;
    @(negedge clk);
    a = {4{32'h1234_5678}}; b = {4{32'h1111_1111}}; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h cout=%b ovf=%b, required all 0",
               busy, done, result, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    issue_op(128'd3, 128'd4, 1'b0, cyc, bc);
    n_checks++;
    if (result !== 128'd7 || cout !== 1'b0 || ovf !== 1'b0 || cyc !== NW + 1 || bc !== NW) begin
      n_fail++;
      $display("FAIL after_reset_op: result=%h cyc=%0d busy_cycles=%0d, required 7 %0d %0d",
               result, cyc, bc, NW + 1, NW);
    end
    $display("test_reset_mid: 3+4 result=%h", result);
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, exp_r;
    logic sv, exp_c, exp_o;
    int cyc, bc;
    for (int i = 0; i < 24; i++) begin
      av = rand_wide();
      bv = rand_wide();
      case ($urandom_range(0, 3))
        0: bv = av;
        1: av[W-1 -: 32] = 32'h7FFF_FFFF;
        default: ;
      endcase
      sv = 1'($urandom_range(0, 1));
      ref_model(av, bv, sv, exp_r, exp_c, exp_o);
      issue_op(av, bv, sv, cyc, bc);
      n_checks++;
      if (result !== exp_r || cout !== exp_c || ovf !== exp_o || cyc !== NW + 1) begin
        n_fail++;
        $display("FAIL random_%0d: result=%h cout=%b ovf=%b cyc=%0d, required %h %b %b %0d",
                 i, result, cout, ovf, cyc, exp_r, exp_c, exp_o, NW + 1);
      end
      $display("random %0d: sub=%b result=%h cout=%b ovf=%b", i, sv, result, cout, ovf);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    test_reset();
    test_carry();
    test_wrap();
    test_sub();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
